// File: rtl/pipelined_prefix_adder.sv
// Pipelined parallel-prefix adder: N-bit a + b + cin with carry-out and signed
// overflow. The carry network is Kogge-Stone (TOPO=0) or Sklansky (TOPO=1),
// with a register bank after every LPS prefix levels (LPS=0: fully
// combinational network) and one output register. All stages advance together
// under a single global stall derived from the output handshake.
module pipelined_prefix_adder #(
  parameter int N    = 32,
  parameter int TOPO = 0,
  parameter int LPS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int LOG   = $clog2(N);
  // Guards the modulo below when the network is fully combinational.
  localparam int LPS_S = (LPS == 0) ? 1 : LPS;

  // Global advance: the whole pipe moves unless a result is stuck at the output.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // One generate iteration per prefix level. Each level owns the signals
  // entering it (either straight from the previous level or from a register
  // bank) and produces the combined group generate/propagate for the next.
  for (genvar k = 0; k < LOG; k++) begin : lvl
    logic [N-1:0] g_in;
    logic [N-1:0] p_in;
    logic [N-1:0] pr_in;   // raw a^b, carried along for sum formation
    logic         ci_in;
    logic         v_in;
    logic [N-1:0] g_out;
    logic [N-1:0] p_out;

    if (k == 0) begin : src
      // Bit-level generate/propagate with carry-in folded into bit 0.
      assign pr_in = a ^ b;
      assign p_in  = pr_in;
      assign g_in  = (a & b) | {{(N-1){1'b0}}, pr_in[0] & cin};
      assign ci_in = cin;
      assign v_in  = in_valid;
    end else if ((LPS != 0) && ((k % LPS_S) == 0)) begin : bank
      // Pipeline bank between level k-1 and level k; holds while stalled.
      always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every bank samples its predecessor's pre-edge value.
        if (rst) begin
          // NOTE: only the valid bit is reset; data of an invalid stage is
          // don't-care, so the wide data registers carry no reset.
          v_in <= 1'b0;
        end else if (adv) begin
          v_in  <= lvl[k-1].v_in;
          g_in  <= lvl[k-1].g_out;
          p_in  <= lvl[k-1].p_out;
          pr_in <= lvl[k-1].pr_in;
          ci_in <= lvl[k-1].ci_in;
        end
      end
    end else begin : thru
      assign v_in  = lvl[k-1].v_in;
      assign g_in  = lvl[k-1].g_out;
      assign p_in  = lvl[k-1].p_out;
      assign pr_in = lvl[k-1].pr_in;
      assign ci_in = lvl[k-1].ci_in;
    end

    // Per-bit combine: partner index is fixed by topology and level, -1 means
    // the bit passes through unchanged at this level.
    for (genvar j = 0; j < N; j++) begin : bitc
      localparam int PJ = (TOPO == 0)
                        ? ((j >= (1 << k)) ? (j - (1 << k)) : -1)
                        : ((((j >> k) & 1) == 1) ? (((j >> k) << k) - 1) : -1);
      if (PJ >= 0) begin : comb
        assign g_out[j] = g_in[j] | (p_in[j] & g_in[PJ]);
        assign p_out[j] = p_in[j] & p_in[PJ];
      end else begin : pass
        assign g_out[j] = g_in[j];
        assign p_out[j] = p_in[j];
      end
    end

    // Group propagate of the last level feeds nothing; sink it explicitly.
    if (k == LOG - 1) begin : sink
      logic unused_p;
      assign unused_p = ^p_out;
    end
  end

  // Signals leaving the prefix network: c_f[i] is the carry out of bit i.
  logic [N-1:0] c_f;
  logic [N-1:0] pr_f;
  logic         ci_f;
  logic         v_f;

  if (LPS != 0) begin : fin_bank
    // Final bank after the last prefix level (may cover fewer than LPS levels).
    always_ff @(posedge clk) begin
      if (rst) begin
        v_f <= 1'b0;
      end else if (adv) begin
        v_f  <= lvl[LOG-1].v_in;
        c_f  <= lvl[LOG-1].g_out;
        pr_f <= lvl[LOG-1].pr_in;
        ci_f <= lvl[LOG-1].ci_in;
      end
    end
  end else begin : fin_comb
    assign v_f  = lvl[LOG-1].v_in;
    assign c_f  = lvl[LOG-1].g_out;
    assign pr_f = lvl[LOG-1].pr_in;
    assign ci_f = lvl[LOG-1].ci_in;
  end

  // Sum bit i uses the carry into bit i, which is the carry out of bit i-1.
  logic [N-1:0] sum_d;
  assign sum_d = pr_f ^ {c_f[N-2:0], ci_f};

  // Output register: results only change on advance, so they hold during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= v_f;
      sum       <= sum_d;
      cout      <= c_f[N-1];
      ovf       <= c_f[N-1] ^ c_f[N-2];
    end
  end

endmodule
